// File: rtl/fp_cmp_pkg.sv
// fp_cmp_pkg: shared types and constants for the floating-point comparator
// and its consumers.
//   compare      : result of comparing operand A against operand B
//   EXP_ALL_ONES : exponent field value marking NaN / Infinity
//   FP_ZERO      : all-zero single-precision bit pattern (+0.0)
package fp_cmp_pkg;

  typedef enum logic [1:0] {
    A_GREATER_THAN_B,
    A_LESS_THAN_B,
    A_EQUALS_B,
    INVALID_INPUTS
  } compare;

  localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;
  localparam logic [31:0] FP_ZERO      = 32'h0;

  // NaN and Infinity both carry an all-ones exponent.
  function automatic logic is_nonfinite(input logic [31:0] x);
    return (x[30:23] == EXP_ALL_ONES);
  endfunction

  // Maps an IEEE-754 bit pattern onto an unsigned key whose ordering
  // matches numeric ordering. Negatives are bit-inverted so a larger
  // magnitude sorts lower; positives get the top bit set so they sort
  // above every negative.
  function automatic logic [31:0] ord_key(input logic [31:0] x);
    return x[31] ? ~x : {1'b1, x[30:0]};
  endfunction

endpackage

// File: rtl/fp_comparator.sv
// fp_comparator: combinational single-precision comparison of A against B.
// Ports:
//   a_i      : operand A (IEEE-754 single, raw bits)
//   b_i      : operand B (IEEE-754 single, raw bits)
//   result_o : INVALID_INPUTS if either operand is NaN/Inf, otherwise the
//              ordering of A relative to B; +0 and -0 compare equal.
module fp_comparator
  import fp_cmp_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output compare      result_o
);

  logic [31:0] key_a;
  logic [31:0] key_b;
  logic        both_zero;

  assign key_a     = ord_key(a_i);
  assign key_b     = ord_key(b_i);
  // Signed zeros map to different keys, so they are caught explicitly.
  assign both_zero = (a_i[30:0] == 31'h0) && (b_i[30:0] == 31'h0);

  always_comb begin
    result_o = A_EQUALS_B;
    if (is_nonfinite(a_i) || is_nonfinite(b_i)) begin
      result_o = INVALID_INPUTS;
    end else if (both_zero) begin
      result_o = A_EQUALS_B;
    end else if (key_a > key_b) begin
      result_o = A_GREATER_THAN_B;
    end else if (key_a < key_b) begin
      result_o = A_LESS_THAN_B;
    end
  end

endmodule

// File: rtl/fp_minmax_tracker.sv
// fp_minmax_tracker: per-frame running min/max of a single-precision stream.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : sample stream handshake
//   in_data, in_last  : sample bits, end-of-frame marker
//   out_valid/out_ready : frame result handshake
//   out_min, out_max  : smallest / largest finite sample (0 if none)
//   out_count         : finite sample count (saturating)
//   out_invalid_count : NaN/Inf sample count (saturating)
//   out_empty         : frame held no finite sample
module fp_minmax_tracker
  import fp_cmp_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_min,
  output logic [31:0]      out_max,
  output logic [CNT_W-1:0] out_count,
  output logic [CNT_W-1:0] out_invalid_count,
  output logic             out_empty
);

  typedef enum logic {ACCUM, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [31:0]      cur_min_q, cur_min_d;
  logic [31:0]      cur_max_q, cur_max_d;
  logic             have_first_q, have_first_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] inv_q, inv_d;

  compare cmp_lo_res;
  compare cmp_hi_res;
  logic   accept;

  fp_comparator u_cmp_lo (
    .a_i      (in_data),
    .b_i      (cur_min_q),
    .result_o (cmp_lo_res)
  );

  fp_comparator u_cmp_hi (
    .a_i      (in_data),
    .b_i      (cur_max_q),
    .result_o (cmp_hi_res)
  );

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    cur_min_d    = cur_min_q;
    cur_max_d    = cur_max_q;
    have_first_d = have_first_q;
    cnt_d        = cnt_q;
    inv_d        = inv_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (is_nonfinite(in_data)) begin
            inv_d = (inv_q == '1) ? inv_q : inv_q + CNT_ONE;
          end else begin
            if (!have_first_q) begin
              cur_min_d    = in_data;
              cur_max_d    = in_data;
              have_first_d = 1'b1;
            end else begin
              // Equal compares keep the stored pattern (first-seen wins).
              if (cmp_lo_res == A_LESS_THAN_B)    cur_min_d = in_data;
              if (cmp_hi_res == A_GREATER_THAN_B) cur_max_d = in_data;
            end
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
          end
          if (in_last) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d      = ACCUM;
          cur_min_d    = FP_ZERO;
          cur_max_d    = FP_ZERO;
          have_first_d = 1'b0;
          cnt_d        = '0;
          inv_d        = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ACCUM;
      cur_min_q    <= FP_ZERO;
      cur_max_q    <= FP_ZERO;
      have_first_q <= 1'b0;
      cnt_q        <= '0;
      inv_q        <= '0;
    end else begin
      state_q      <= state_d;
      cur_min_q    <= cur_min_d;
      cur_max_q    <= cur_max_d;
      have_first_q <= have_first_d;
      cnt_q        <= cnt_d;
      inv_q        <= inv_d;
    end
  end

  // Results are only presented in DONE; elsewhere every output reads zero.
  assign out_min           = (out_valid && have_first_q) ? cur_min_q : FP_ZERO;
  assign out_max           = (out_valid && have_first_q) ? cur_max_q : FP_ZERO;
  assign out_count         = out_valid ? cnt_q : '0;
  assign out_invalid_count = out_valid ? inv_q : '0;
  assign out_empty         = out_valid && !have_first_q;

endmodule
